// File: rtl/pipelined_control_unit.sv
// rtl/pipelined_control_unit.sv - RV32I pipelined control: decode, D/E, E/M, M/W control registers
// Branch/jump resolution happens in Execute from the registered control word and ALU flags.
module pipelined_control_unit #(
  parameter int ALUCTRL_W     = 4,
  parameter bit EN_EXT_BRANCH = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           opD,
  input  logic [2:0]           funct3D,
  input  logic                 funct7_5D,
  input  logic                 FlushE,
  input  logic                 ZeroE,
  input  logic                 NegE,
  input  logic                 OvfE,
  input  logic                 CarryE,
  output logic [2:0]           ImmSrcD,
  output logic                 IllegalD,
  output logic                 RegWriteE,
  output logic                 ALUSrcAE,
  output logic                 ALUSrcBE,
  output logic                 JalrE,
  output logic [1:0]           ResultSrcE,
  output logic [ALUCTRL_W-1:0] ALUControlE,
  output logic                 PCSrcE,
  output logic                 RegWriteM,
  output logic                 MemWriteM,
  output logic [2:0]           Funct3M,
  output logic [1:0]           ResultSrcW,
  output logic                 RegWriteW,
  output logic                 IllegalW
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [ALUCTRL_W-1:0] ALU_ADD   = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB   = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_AND   = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_OR    = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR   = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT   = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLTU  = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL   = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL   = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA   = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_PASSB = ALUCTRL_W'(10);

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  logic                 reg_write_d, mem_write_d, alu_src_a_d, alu_src_b_d;
  logic                 branch_d, jump_d, jalr_d, illegal_d;
  logic [1:0]           result_src_d;
  logic [2:0]           imm_src_d;
  logic [ALUCTRL_W-1:0] alu_ctrl_d, arith_op;

  // Shared R/I arithmetic decode; sub exists only for register-register forms.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3D)
      3'b000: arith_op = (funct7_5D && opD == OP_R) ? ALU_SUB : ALU_ADD;
      3'b001: arith_op = ALU_SLL;
      3'b010: arith_op = ALU_SLT;
      3'b011: arith_op = ALU_SLTU;
      3'b100: arith_op = ALU_XOR;
      3'b101: arith_op = funct7_5D ? ALU_SRA : ALU_SRL;
      3'b110: arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  always_comb begin
    reg_write_d  = 1'b0;
    mem_write_d  = 1'b0;
    alu_src_a_d  = 1'b0;
    alu_src_b_d  = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    jalr_d       = 1'b0;
    illegal_d    = 1'b0;
    result_src_d = 2'b00;
    imm_src_d    = IMM_I;
    alu_ctrl_d   = ALU_ADD;
    case (opD)
      OP_LOAD: begin
        if (funct3D == 3'b011 || funct3D[2:1] == 2'b11) begin
          illegal_d = 1'b1;
        end else begin
          reg_write_d  = 1'b1;
          alu_src_b_d  = 1'b1;
          result_src_d = 2'b01;
        end
      end
      OP_STORE: begin
        if (funct3D == 3'b011 || funct3D[2]) begin
          illegal_d = 1'b1;
        end else begin
          mem_write_d = 1'b1;
          alu_src_b_d = 1'b1;
          imm_src_d   = IMM_S;
        end
      end
      OP_R, OP_I: begin
        reg_write_d = 1'b1;
        alu_src_b_d = (opD == OP_I);
        alu_ctrl_d  = arith_op;
      end
      OP_BRANCH: begin
        if (funct3D[2:1] == 2'b01 || (funct3D[2] && EN_EXT_BRANCH == 1'b0)) begin
          illegal_d = 1'b1;
        end else begin
          branch_d   = 1'b1;
          imm_src_d  = IMM_B;
          alu_ctrl_d = ALU_SUB;
        end
      end
      OP_JAL: begin
        jump_d       = 1'b1;
        reg_write_d  = 1'b1;
        result_src_d = 2'b10;
        imm_src_d    = IMM_J;
      end
      OP_JALR: begin
        jump_d       = 1'b1;
        jalr_d       = 1'b1;
        reg_write_d  = 1'b1;
        alu_src_b_d  = 1'b1;
        result_src_d = 2'b10;
      end
      OP_LUI: begin
        reg_write_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_src_d   = IMM_U;
        alu_ctrl_d  = ALU_PASSB;
      end
      OP_AUIPC: begin
        reg_write_d = 1'b1;
        alu_src_a_d = 1'b1;
        alu_src_b_d = 1'b1;
        imm_src_d   = IMM_U;
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign ImmSrcD  = imm_src_d;
  assign IllegalD = illegal_d;

  logic       branch_e, jump_e, mem_write_e, illegal_e, illegal_m;
  logic [2:0] funct3_e;
  logic [1:0] result_src_m;

  // A flush inserts a bubble: every field, including the ALU op, returns to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteE   <= 1'b0;
      ALUSrcAE    <= 1'b0;
      ALUSrcBE    <= 1'b0;
      JalrE       <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= ALU_ADD;
      branch_e    <= 1'b0;
      jump_e      <= 1'b0;
      mem_write_e <= 1'b0;
      illegal_e   <= 1'b0;
      funct3_e    <= 3'b000;
    end else if (FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcAE    <= 1'b0;
      ALUSrcBE    <= 1'b0;
      JalrE       <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= ALU_ADD;
      branch_e    <= 1'b0;
      jump_e      <= 1'b0;
      mem_write_e <= 1'b0;
      illegal_e   <= 1'b0;
      funct3_e    <= 3'b000;
    end else begin
      RegWriteE   <= reg_write_d;
      ALUSrcAE    <= alu_src_a_d;
      ALUSrcBE    <= alu_src_b_d;
      JalrE       <= jalr_d;
      ResultSrcE  <= result_src_d;
      ALUControlE <= alu_ctrl_d;
      branch_e    <= branch_d;
      jump_e      <= jump_d;
      mem_write_e <= mem_write_d;
      illegal_e   <= illegal_d;
      funct3_e    <= funct3D;
    end
  end

  logic cond_e;

  always_comb begin
    cond_e = 1'b0;
    case (funct3_e)
      3'b000:  cond_e = ZeroE;
      3'b001:  cond_e = !ZeroE;
      3'b100:  cond_e = NegE ^ OvfE;
      3'b101:  cond_e = !(NegE ^ OvfE);
      3'b110:  cond_e = !CarryE;
      3'b111:  cond_e = CarryE;
      default: cond_e = 1'b0;
    endcase
  end

  assign PCSrcE = (branch_e & cond_e) | jump_e;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM    <= 1'b0;
      MemWriteM    <= 1'b0;
      Funct3M      <= 3'b000;
      result_src_m <= 2'b00;
      illegal_m    <= 1'b0;
      RegWriteW    <= 1'b0;
      ResultSrcW   <= 2'b00;
      IllegalW     <= 1'b0;
    end else begin
      RegWriteM    <= RegWriteE;
      MemWriteM    <= mem_write_e;
      Funct3M      <= funct3_e;
      result_src_m <= ResultSrcE;
      illegal_m    <= illegal_e;
      RegWriteW    <= RegWriteM;
      ResultSrcW   <= result_src_m;
      IllegalW     <= illegal_m;
    end
  end

endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb/tb_pipelined_control_unit.sv - randomized check of pipelined_control_unit against a behavioural model
// Instance 0 has the extended branch set, instance 1 only beq/bne.
module tb_pipelined_control_unit;

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic       asa;
    logic       asb;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       br;
    logic       jmp;
    logic       jalr;
    logic       ill;
    logic [2:0] f3;
  } ctl_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opD = 7'b0010011;
  logic [2:0]  funct3D = 3'b000;
  logic        funct7_5D = 1'b0;
  logic        FlushE = 1'b0;
  logic [31:0] a = 32'd0, b = 32'd0, diff;
  logic        ZeroE, NegE, OvfE, CarryE;

  assign diff   = a - b;
  assign ZeroE  = (diff == 32'd0);
  assign NegE   = diff[31];
  assign OvfE   = (a[31] ^ b[31]) & (a[31] ^ diff[31]);
  assign CarryE = (a >= b);

  logic [2:0] imm_src [2];
  logic       ill_d   [2];
  logic       rw_e    [2];
  logic       asa_e   [2];
  logic       asb_e   [2];
  logic       jalr_e  [2];
  logic [1:0] rs_e    [2];
  logic [3:0] alu_e   [2];
  logic       pcsrc_e [2];
  logic       rw_m    [2];
  logic       mw_m    [2];
  logic [2:0] f3_m    [2];
  logic [1:0] rs_w    [2];
  logic       rw_w    [2];
  logic       ill_w   [2];

  pipelined_control_unit #(.ALUCTRL_W(4), .EN_EXT_BRANCH(1'b1)) dut_ext (
    .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7_5D(funct7_5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
    .ImmSrcD(imm_src[0]), .IllegalD(ill_d[0]), .RegWriteE(rw_e[0]), .ALUSrcAE(asa_e[0]),
    .ALUSrcBE(asb_e[0]), .JalrE(jalr_e[0]), .ResultSrcE(rs_e[0]), .ALUControlE(alu_e[0]),
    .PCSrcE(pcsrc_e[0]), .RegWriteM(rw_m[0]), .MemWriteM(mw_m[0]), .Funct3M(f3_m[0]),
    .ResultSrcW(rs_w[0]), .RegWriteW(rw_w[0]), .IllegalW(ill_w[0])
  );

  pipelined_control_unit #(.ALUCTRL_W(4), .EN_EXT_BRANCH(1'b0)) dut_base (
    .clk(clk), .rst_n(rst_n), .opD(opD), .funct3D(funct3D), .funct7_5D(funct7_5D),
    .FlushE(FlushE), .ZeroE(ZeroE), .NegE(NegE), .OvfE(OvfE), .CarryE(CarryE),
    .ImmSrcD(imm_src[1]), .IllegalD(ill_d[1]), .RegWriteE(rw_e[1]), .ALUSrcAE(asa_e[1]),
    .ALUSrcBE(asb_e[1]), .JalrE(jalr_e[1]), .ResultSrcE(rs_e[1]), .ALUControlE(alu_e[1]),
    .PCSrcE(pcsrc_e[1]), .RegWriteM(rw_m[1]), .MemWriteM(mw_m[1]), .Funct3M(f3_m[1]),
    .ResultSrcW(rs_w[1]), .RegWriteW(rw_w[1]), .IllegalW(ill_w[1])
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d got=%0h want=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Control word straight from the instruction-set rules.
  function automatic ctl_t dec(input logic [6:0] op, input logic [2:0] f3, input logic f75, input bit ext);
    ctl_t c;
    logic [3:0] arith [8];
    arith = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
    c = '0;
    c.f3 = f3;
    case (op)
      7'h03: if (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) begin c.rw = 1; c.asb = 1; c.rs = 2'd1; end
             else c.ill = 1;
      7'h23: if (f3 < 3'd3) begin c.mw = 1; c.asb = 1; c.imm = 3'd1; end
             else c.ill = 1;
      7'h33, 7'h13: begin
        c.rw  = 1;
        c.asb = (op == 7'h13);
        c.alu = arith[f3];
        if (f3 == 3'd5 && f75) c.alu = 4'd9;
        if (f3 == 3'd0 && f75 && op == 7'h33) c.alu = 4'd1;
      end
      7'h63: if (f3 < 3'd2 || (ext && f3 >= 3'd4)) begin c.br = 1; c.imm = 3'd2; c.alu = 4'd1; end
             else c.ill = 1;
      7'h6f: begin c.jmp = 1; c.rw = 1; c.rs = 2'd2; c.imm = 3'd3; end
      7'h67: begin c.jmp = 1; c.jalr = 1; c.rw = 1; c.asb = 1; c.rs = 2'd2; end
      7'h37: begin c.rw = 1; c.asb = 1; c.imm = 3'd4; c.alu = 4'd10; end
      7'h17: begin c.rw = 1; c.asa = 1; c.asb = 1; c.imm = 3'd4; end
      default: c.ill = 1;
    endcase
    return c;
  endfunction

  function automatic bit taken(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return x == y;
      3'd1: return x != y;
      3'd4: return $signed(x) < $signed(y);
      3'd5: return $signed(x) >= $signed(y);
      3'd6: return x < y;
      3'd7: return x >= y;
      default: return 1'b0;
    endcase
  endfunction

  ctl_t me [2] = '{default: '0};
  ctl_t mm [2] = '{default: '0};
  ctl_t mw [2] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        me[k] <= '0;
        mm[k] <= '0;
        mw[k] <= '0;
      end else begin
        me[k] <= FlushE ? ctl_t'('0) : dec(opD, funct3D, funct7_5D, k == 0);
        mm[k] <= me[k];
        mw[k] <= mm[k];
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ctl_t dk;
      dk = dec(opD, funct3D, funct7_5D, k == 0);
      chk("ImmSrcD", k, 32'(imm_src[k]), 32'(dk.imm));
      chk("IllegalD", k, 32'(ill_d[k]), 32'(dk.ill));
      chk("RegWriteE", k, 32'(rw_e[k]), 32'(me[k].rw));
      chk("ALUSrcAE", k, 32'(asa_e[k]), 32'(me[k].asa));
      chk("ALUSrcBE", k, 32'(asb_e[k]), 32'(me[k].asb));
      chk("JalrE", k, 32'(jalr_e[k]), 32'(me[k].jalr));
      chk("ResultSrcE", k, 32'(rs_e[k]), 32'(me[k].rs));
      chk("ALUControlE", k, 32'(alu_e[k]), 32'(me[k].alu));
      chk("PCSrcE", k, 32'(pcsrc_e[k]), 32'(me[k].jmp | (me[k].br & taken(me[k].f3, a, b))));
      chk("RegWriteM", k, 32'(rw_m[k]), 32'(mm[k].rw));
      chk("MemWriteM", k, 32'(mw_m[k]), 32'(mm[k].mw));
      chk("Funct3M", k, 32'(f3_m[k]), 32'(mm[k].f3));
      chk("ResultSrcW", k, 32'(rs_w[k]), 32'(mw[k].rs));
      chk("RegWriteW", k, 32'(rw_w[k]), 32'(mw[k].rw));
      chk("IllegalW", k, 32'(ill_w[k]), 32'(mw[k].ill));
    end
  end

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic f75, input logic fl);
    opD = op;
    funct3D = f3;
    funct7_5D = f75;
    FlushE = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] ops [9];

  initial begin
    ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_RegWriteE", 0, 32'(rw_e[0]), 32'd0);
    chk("rst_RegWriteW", 0, 32'(rw_w[0]), 32'd0);
    tick();
    rst_n = 1'b1;

    drive(7'h33, 3'd0, 1'b1, 1'b0); tick(); drive(7'h13, 3'd0, 1'b0, 1'b0);
    @(negedge clk); chk("lit_r_sub", 0, 32'(alu_e[0]), 32'd1);
    tick(); drive(7'h13, 3'd0, 1'b1, 1'b0); tick(); drive(7'h13, 3'd0, 1'b0, 1'b0);
    @(negedge clk); chk("lit_i_addf7", 0, 32'(alu_e[0]), 32'd0);
    tick(); drive(7'h13, 3'd5, 1'b1, 1'b0); tick(); drive(7'h13, 3'd0, 1'b0, 1'b0);
    @(negedge clk); chk("lit_srai", 0, 32'(alu_e[0]), 32'd9);

    a = 32'd1; b = 32'd2;
    tick(); drive(7'h63, 3'd4, 1'b0, 1'b0); tick(); drive(7'h13, 3'd0, 1'b0, 1'b0);
    @(negedge clk); chk("lit_blt", 0, 32'(pcsrc_e[0]), 32'd1);
    tick(); drive(7'h63, 3'd7, 1'b0, 1'b0); tick(); drive(7'h13, 3'd0, 1'b0, 1'b0);
    @(negedge clk); chk("lit_bgeu", 0, 32'(pcsrc_e[0]), 32'd0);
    tick(); drive(7'h63, 3'd1, 1'b0, 1'b0); tick(); drive(7'h13, 3'd0, 1'b0, 1'b0);
    @(negedge clk); chk("lit_bne", 0, 32'(pcsrc_e[0]), 32'd1);

    tick(); drive(7'h67, 3'd0, 1'b0, 1'b0); tick(); drive(7'h23, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_jalr_pc", 0, 32'(pcsrc_e[0]), 32'd1);
    chk("lit_jalr_j", 0, 32'(jalr_e[0]), 32'd1);
    chk("lit_jalr_rs", 0, 32'(rs_e[0]), 32'd2);
    tick(); tick();
    @(negedge clk); chk("lit_jalr_rww", 0, 32'(rw_w[0]), 32'd1);

    tick(); drive(7'h6f, 3'd0, 1'b0, 1'b1); tick(); drive(7'h37, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_flush_pc", 0, 32'(pcsrc_e[0]), 32'd0);
    chk("lit_flush_rw", 0, 32'(rw_e[0]), 32'd0);
    tick(); drive(7'h23, 3'd2, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_lui_rw", 0, 32'(rw_e[0]), 32'd1);
    chk("lit_lui_alu", 0, 32'(alu_e[0]), 32'd10);

    tick(); drive(7'h7f, 3'd0, 1'b0, 1'b0); #1;
    chk("lit_illD", 0, 32'(ill_d[0]), 32'd1);
    tick(); drive(7'h23, 3'd2, 1'b0, 1'b0); tick();
    @(negedge clk); chk("lit_illW_early", 0, 32'(ill_w[0]), 32'd0);
    tick();
    @(negedge clk); chk("lit_illW", 0, 32'(ill_w[0]), 32'd1);
    tick();
    @(negedge clk); chk("lit_illW_after", 0, 32'(ill_w[0]), 32'd0);

    tick(); drive(7'h63, 3'd4, 1'b0, 1'b0); #1;
    chk("lit_blt_base", 1, 32'(ill_d[1]), 32'd1);
    chk("lit_blt_ext", 0, 32'(ill_d[0]), 32'd0);

    tick(); drive(7'h33, 3'd0, 1'b0, 1'b0); tick(); #1;
    rst_n = 1'b0; #1;
    chk("lit_rst_rwE", 0, 32'(rw_e[0]), 32'd0);
    chk("lit_rst_rwM", 0, 32'(rw_m[0]), 32'd0);
    tick(); rst_n = 1'b1; drive(7'h23, 3'd2, 1'b0, 1'b0);
    tick(); drive(7'h13, 3'd0, 1'b0, 1'b0); tick();
    @(negedge clk); chk("lit_rst_sw", 0, 32'(mw_m[0]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 99) < 85) opD = ops[$urandom_range(0, 8)];
      else opD = 7'($urandom);
      funct3D = 3'($urandom);
      funct7_5D = 1'($urandom);
      FlushE = ($urandom_range(0, 9) == 0);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = {~a[31], a[30:0]};
        default: b = $urandom;
      endcase
    end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_control_unit.md
Name: pipelined_control_unit

Overview:
Successor to the single-cycle control unit for the five-stage pipelined RV32I core. It decodes op/funct3/funct7_5 in Decode and carries the control word through the D/E, E/M and M/W pipeline registers. It resolves the full branch set plus jal/jalr in Execute and flags illegal opcodes down to Writeback. The hazard unit drives FlushE and consumes RegWriteE/ResultSrcE for load-use detection.

Parameters:
ALUCTRL_W, 4, width of ALUControl; must be >= 4.
EN_EXT_BRANCH, 1, 1 = beq/bne/blt/bge/bltu/bgeu; 0 = beq/bne only, other branch funct3 values are illegal.

Ports:
clk  in  1  core clock, all registers on rising edge
rst_n  in  1  asynchronous active-low reset
opD  in  7  instruction[6:0] in Decode
funct3D  in  3  instruction[14:12]
funct7_5D  in  1  instruction[30]
FlushE  in  1  load D/E control register with a bubble
ZeroE  in  1  ALU result == 0
NegE  in  1  ALU result[31]
OvfE  in  1  ALU signed overflow
CarryE  in  1  carry-out of A+~B+1 (1 = A >=u B)
ImmSrcD  out  3  000 I, 001 S, 010 B, 011 J, 100 U
IllegalD  out  1  unsupported encoding in Decode (combinational)
RegWriteE, ALUSrcAE, ALUSrcBE, JalrE  out  1 each  Execute control
ResultSrcE  out  2  00 ALU, 01 Mem, 10 PC+4
ALUControlE  out  ALUCTRL_W  0 add, 1 sub, 2 and, 3 or, 4 xor, 5 slt, 6 sltu, 7 sll, 8 srl, 9 sra, 10 passB
PCSrcE  out  1  take branch/jump (combinational from E register and flags)
RegWriteM, MemWriteM  out  1 each
Funct3M  out  3  load/store size for memory unit
ResultSrcW  out  2
RegWriteW, IllegalW  out  1 each

Behaviour:
- Decode (comb.): lw-class 0000011: RegWrite, ALUSrcB, ResultSrc=01, I, add. Store 0100011: MemWrite, ALUSrcB, S, add. R 0110011 and I-ALU 0010011: RegWrite, funct3 selects op; funct3=000 with funct7_5=1 is sub only for R-type; funct3=101 with funct7_5 gives sra/srl for both. Branch 1100011: Branch, B, sub. jal 1101111: Jump, RegWrite, ResultSrc=10, J. jalr 1100111: Jump, Jalr, RegWrite, ALUSrcB, ResultSrc=10, I, add. lui 0110111: RegWrite, ALUSrcB, U, passB. auipc 0010111: RegWrite, ALUSrcA=PC, ALUSrcB, U, add.
- Any other opcode, branch funct3 010/011, branch funct3 100-111 when EN_EXT_BRANCH=0, or load/store funct3 outside {000,001,010,100,101}/{000,001,010}: IllegalD=1, all write/branch/jump controls 0 (bubble), ImmSrcD=000.
- D/E register: on FlushE, or if rst_n is low, all fields clear to 0, including Branch, Jump, Illegal and ALUControl=add. Otherwise it captures the decode word. There is no stall input: the hazard unit freezes the fetch/decode registers only.
- Branch condition on funct3E: 000 Zero; 001 !Zero; 100 Neg^Ovf; 101 !(Neg^Ovf); 110 !Carry; 111 Carry.
- PCSrcE = (BranchE & cond) | JumpE. It is 0 during reset and in any bubble.
- E/M and M/W registers: always enabled, clear to 0 on reset. Latency: decode to E = 1 cycle, to M = 2, to W = 3.
- Reset mid-stream: all pipeline control bits become 0 asynchronously. The first decoded instruction after rst_n deasserts reaches Execute on the next rising edge.
- Simultaneous FlushE and valid decode: flush wins and the instruction is dropped. Flushing does not affect instructions already in M/W.
- IllegalW is a one-cycle pulse aligned with the offending instruction's Writeback slot.

Test Plan:
- Reset: hold rst_n=0 mid-run with add in D -> every E/M/W output is 0 immediately; release, then decode sw -> MemWriteM=1 two edges later.
- ALU decode: R-type funct3=000 f7_5=1 -> ALUControlE=1; I-type funct3=000 f7_5=1 -> 0; funct3=101 f7_5=1 -> 9.
- Branches: blt (funct3=100) with Neg=1,Ovf=0 -> PCSrcE=1; bgeu with Carry=0 -> 0; bne with Zero=0 -> 1.
- Jumps: jalr -> PCSrcE=1, JalrE=1, ResultSrcE=10, RegWriteW=1 three cycles after decode.
- FlushE: assert FlushE while jal is in D -> next cycle PCSrcE=0, RegWriteE=0; the following instruction flows normally.
- Illegal: opD=1111111 -> IllegalD=1, and IllegalW=1 for exactly one cycle, three edges later; with EN_EXT_BRANCH=0, funct3=100 branch -> IllegalD=1.
